// File: rtl/e203_tcm_sram_ctrl.sv
// ICB-to-SRAM bridge for the E203 TCM with idle light-sleep control.
// Optional macro E203_TCM_SRAM_CTRL_RSP_HOLD_EN adds a read-data hold register for stalled responses.
module e203_tcm_sram_ctrl #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int USR_W   = 1,
  parameter int LS_IDLE = 8,
  localparam int MW     = DW / 8,
  localparam int OW     = $clog2(MW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_icb_cmd_valid,
  output logic             i_icb_cmd_ready,
  input  logic             i_icb_cmd_read,
  input  logic [AW-1:0]    i_icb_cmd_addr,
  input  logic [DW-1:0]    i_icb_cmd_wdata,
  input  logic [MW-1:0]    i_icb_cmd_wmask,
  input  logic [USR_W-1:0] i_icb_cmd_usr,
  output logic             i_icb_rsp_valid,
  input  logic             i_icb_rsp_ready,
  output logic [DW-1:0]    i_icb_rsp_rdata,
  output logic [USR_W-1:0] i_icb_rsp_usr,
  output logic             ram_cs,
  output logic             ram_we,
  output logic [AW-OW-1:0] ram_addr,
  output logic [MW-1:0]    ram_wem,
  output logic [DW-1:0]    ram_din,
  input  logic [DW-1:0]    ram_dout,
  output logic             ram_ls,
  output logic             ctrl_active
);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } state_t;

  localparam logic [7:0] LS_M1 = 8'(LS_IDLE - 1);

  state_t           state;
  logic [7:0]       idle_cnt;
  logic             rsp_valid;
  logic             rd_flag;
  logic [USR_W-1:0] usr_r;
  logic             cmd_hsk;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^i_icb_cmd_addr[OW-1:0];

  assign i_icb_cmd_ready = (state == ACTIVE)
                         & (~rsp_valid | i_icb_rsp_ready);
  assign cmd_hsk  = i_icb_cmd_valid & i_icb_cmd_ready;

  assign ram_cs   = cmd_hsk;
  assign ram_we   = ~i_icb_cmd_read;
  assign ram_addr = i_icb_cmd_addr[AW-1:OW];
  assign ram_wem  = i_icb_cmd_read ? '0 : i_icb_cmd_wmask;
  assign ram_din  = i_icb_cmd_wdata;

  assign i_icb_rsp_valid = rsp_valid;
  assign i_icb_rsp_usr   = usr_r;
  assign ram_ls          = (state != ACTIVE);
  assign ctrl_active     = rsp_valid | (state == WAKE);

  // Response slot: filled on command transfer, drained on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rd_flag   <= 1'b0;
      usr_r     <= '0;
    end else if (cmd_hsk) begin
      rsp_valid <= 1'b1;
      rd_flag   <= i_icb_cmd_read;
      usr_r     <= i_icb_cmd_usr;
    end else if (i_icb_rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef E203_TCM_SRAM_CTRL_RSP_HOLD_EN
  logic          rsp_first;
  logic [DW-1:0] hold_q;

  // Capture SRAM output at the end of a first response cycle that stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_first <= 1'b0;
      hold_q    <= '0;
    end else begin
      rsp_first <= cmd_hsk;
      if (rsp_valid & rsp_first & ~i_icb_rsp_ready)
        hold_q <= ram_dout;
    end
  end

  assign i_icb_rsp_rdata = ~rd_flag   ? '0 :
                           rsp_first ? ram_dout : hold_q;
`else
  assign i_icb_rsp_rdata = rd_flag ? ram_dout : '0;
`endif

  // Power FSM with saturating idle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACTIVE;
      idle_cnt <= 8'd0;
    end else begin
      unique case (state)
        ACTIVE: begin
          if (i_icb_cmd_valid | rsp_valid) begin
            idle_cnt <= 8'd0;
          end else if (idle_cnt == LS_M1) begin
            idle_cnt <= 8'd0;
            state    <= SLEEP;
          end else if (idle_cnt != 8'hFF) begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        SLEEP: begin
          idle_cnt <= 8'd0;
          if (i_icb_cmd_valid)
            state <= WAKE;
        end
        WAKE: begin
          idle_cnt <= 8'd0;
          state    <= ACTIVE;
        end
        default: begin
          idle_cnt <= 8'd0;
          state    <= ACTIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e203_tcm_sram_ctrl.sv
// Directed self-checking bench for e203_tcm_sram_ctrl.
// Expectations follow E203_TCM_SRAM_CTRL_RSP_HOLD_EN when defined.
module tb_e203_tcm_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic [0:0]  cmd_usr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [0:0]  rsp_usr;
  logic        ram_cs, ram_we, ram_ls, ctrl_active;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din, ram_dout;

  logic [31:0] mem [0:15];
  logic [31:0] sram_q;
  logic        ovr_en;
  logic [31:0] ovr_val;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  e203_tcm_sram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(cmd_ready),
    .i_icb_cmd_read(cmd_read), .i_icb_cmd_addr(cmd_addr),
    .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
    .i_icb_cmd_usr(cmd_usr),
    .i_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready),
    .i_icb_rsp_rdata(rsp_rdata), .i_icb_rsp_usr(rsp_usr),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_ls(ram_ls), .ctrl_active(ctrl_active)
  );

  assign ram_dout = ovr_en ? ovr_val : sram_q;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b])
            mem[ram_addr[3:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
      end else begin
        sram_q <= mem[ram_addr[3:0]];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd,
                       input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic u);
    @(negedge clk);
    cmd_valid = v; cmd_read = rd; cmd_addr = a;
    cmd_wdata = d; cmd_wmask = m; cmd_usr = u;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 1'b0);
  endtask

  logic [31:0] stall_exp;
  logic [15:0] ra [0:3];
  logic [31:0] rd_exp [0:3];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    sram_q = 32'h0; ovr_en = 1'b0; ovr_val = 32'h0;
    rst_n = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b0; cmd_read = 1'b1; cmd_addr = '0;
    cmd_wdata = '0; cmd_wmask = '0; cmd_usr = '0;
    #22;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_ls", 32'(ram_ls), 0);
    chk("rst_active", 32'(ctrl_active), 0);
    chk("rst_cs", 32'(ram_cs), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    rst_n = 1'b1;

    drive(1, 0, 16'h0010, 32'hDEADBEEF, 4'hF, 1);
    chk("w_cs", 32'(ram_cs), 1);
    chk("w_we", 32'(ram_we), 1);
    chk("w_addr", 32'(ram_addr), 32'h4);
    chk("w_wem", 32'(ram_wem), 32'hF);
    chk("w_din", ram_din, 32'hDEADBEEF);
    drive(1, 1, 16'h0010, 32'h0, 4'hF, 0);
    chk("w_rsp_valid", 32'(rsp_valid), 1);
    chk("w_rsp_rdata", rsp_rdata, 0);
    chk("w_rsp_usr", 32'(rsp_usr), 1);
    chk("r_cs", 32'(ram_cs), 1);
    chk("r_we", 32'(ram_we), 0);
    chk("r_wem", 32'(ram_wem), 0);
    idle();
    chk("r_rsp_valid", 32'(rsp_valid), 1);
    chk("r_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("r_rsp_usr", 32'(rsp_usr), 0);
    chk("r_ctrl_active", 32'(ctrl_active), 1);
    idle();
    chk("r_rsp_done", 32'(rsp_valid), 0);

    drive(1, 0, 16'h0020, 32'h0000AB00, 4'h2, 0);
    chk("bw_wem", 32'(ram_wem), 32'h2);
    chk("bw_we", 32'(ram_we), 1);
    chk("bw_addr", 32'(ram_addr), 32'h8);
    idle();
    chk("bw_rsp_valid", 32'(rsp_valid), 1);
    chk("bw_rsp_rdata", rsp_rdata, 0);

    ra[0] = 16'h0010; ra[1] = 16'h0020;
    ra[2] = 16'h0010; ra[3] = 16'h0020;
    rd_exp[0] = 32'hDEADBEEF; rd_exp[1] = 32'h0000AB00;
    rd_exp[2] = 32'hDEADBEEF; rd_exp[3] = 32'h0000AB00;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        drive(1, 1, ra[i], 32'h0, 4'h0, 1'(i % 2 == 0));
        chk($sformatf("b2b_cs%0d", i), 32'(ram_cs), 1);
      end else begin
        idle();
      end
      if (i > 0) begin
        chk($sformatf("b2b_vld%0d", i - 1), 32'(rsp_valid), 1);
        chk($sformatf("b2b_dat%0d", i - 1), rsp_rdata, rd_exp[i-1]);
        chk($sformatf("b2b_usr%0d", i - 1), 32'(rsp_usr),
            32'((i - 1) % 2 == 0));
      end
    end

    drive(1, 1, 16'h0010, 32'h0, 4'h0, 1);
    chk("st_cs", 32'(ram_cs), 1);
    rsp_ready = 1'b0;
    drive(1, 1, 16'h0020, 32'h0, 4'h0, 0);
    chk("st_vld0", 32'(rsp_valid), 1);
    chk("st_dat0", rsp_rdata, 32'hDEADBEEF);
    chk("st_rdy0", 32'(cmd_ready), 0);
    chk("st_cs0", 32'(ram_cs), 0);
`ifdef E203_TCM_SRAM_CTRL_RSP_HOLD_EN
    stall_exp = 32'hDEADBEEF;
`else
    stall_exp = 32'h12345678;
`endif
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      ovr_en = 1'b1; ovr_val = 32'h12345678;
      #1;
      chk($sformatf("st_vld%0d", i), 32'(rsp_valid), 1);
      chk($sformatf("st_dat%0d", i), rsp_rdata, stall_exp);
      chk($sformatf("st_usr%0d", i), 32'(rsp_usr), 1);
      chk($sformatf("st_rdy%0d", i), 32'(cmd_ready), 0);
      chk($sformatf("st_cs%0d", i), 32'(ram_cs), 0);
    end
    @(negedge clk);
    ovr_en = 1'b0; rsp_ready = 1'b1; cmd_valid = 1'b0;
    #1;
    chk("st_rel_vld", 32'(rsp_valid), 1);
    chk("st_rel_rdy", 32'(cmd_ready), 1);

    for (int i = 1; i <= 8; i++) begin
      idle();
      chk($sformatf("ls_idle%0d", i), 32'(ram_ls), 0);
    end
    idle();
    chk("ls_on", 32'(ram_ls), 1);
    chk("ls_rdy", 32'(cmd_ready), 0);
    chk("ls_act", 32'(ctrl_active), 0);
    drive(1, 1, 16'h0020, 32'h0, 4'h0, 1);
    chk("sl_cs", 32'(ram_cs), 0);
    chk("sl_ls", 32'(ram_ls), 1);
    @(negedge clk); #1;
    chk("wk_ls", 32'(ram_ls), 1);
    chk("wk_act", 32'(ctrl_active), 1);
    chk("wk_cs", 32'(ram_cs), 0);
    @(negedge clk); #1;
    chk("wk_done_ls", 32'(ram_ls), 0);
    chk("wk_done_cs", 32'(ram_cs), 1);
    idle();
    chk("wk_rsp_vld", 32'(rsp_valid), 1);
    chk("wk_rsp_dat", rsp_rdata, 32'h0000AB00);
    chk("wk_rsp_usr", 32'(rsp_usr), 1);

    for (int i = 0; i < 7; i++) idle();
    drive(1, 1, 16'h0010, 32'h0, 4'h0, 0);
    chk("blk_cs", 32'(ram_cs), 1);
    idle();
    chk("blk_ls", 32'(ram_ls), 0);
    chk("blk_vld", 32'(rsp_valid), 1);

    drive(1, 1, 16'h0010, 32'h0, 4'h0, 1);
    rsp_ready = 1'b0;
    idle();
    chk("rs_vld", 32'(rsp_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_drop", 32'(rsp_valid), 0);
    chk("rs_act", 32'(ctrl_active), 0);
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("rs_none%0d", i), 32'(rsp_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
